// File: rtl/riscv_pipe_pkg.sv
// Common types and helpers for the pipeline-stage slice.
`include "riscv_config.svh"

package riscv_pipe_pkg;

    typedef logic [1:0] count_t;

    function automatic count_t slot_count(input logic main_valid, input logic skid_valid);
        return count_t'({1'b0, main_valid}) + count_t'({1'b0, skid_valid});
    endfunction

endpackage

// File: rtl/riscv_config.svh
// Shared build configuration for the RISC-V pipeline slice.
// RISCV_PIPE_SKID_EN, when defined (e.g. +define+RISCV_PIPE_SKID_EN), selects two-slot skid stages.
`ifndef RISCV_CONFIG_SVH
`define RISCV_CONFIG_SVH

`ifndef XLEN
`define XLEN 32
`endif

`endif

// File: rtl/riscv_pipe_slot.sv
// One payload slot: data register plus valid flag; flush and reset restore RESET_VAL.
`include "riscv_config.svh"

module riscv_pipe_slot #(
    parameter int unsigned     DW        = `XLEN,
    parameter logic [DW-1:0]   RESET_VAL = '0
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_clr,
    input  logic          i_load,
    input  logic          i_unload,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    output logic [DW-1:0] o_data
);

    // Unload drops only the valid flag; the data keeps its last value.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_valid <= 1'b0;
            o_data  <= RESET_VAL;
        end else if (i_clr) begin
            o_valid <= 1'b0;
            o_data  <= RESET_VAL;
        end else if (i_load) begin
            o_valid <= 1'b1;
            o_data  <= i_data;
        end else if (i_unload) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/riscv_pipe_stage.sv
// Valid/ready pipeline register stage; RISCV_PIPE_SKID_EN adds a skid slot and a registered o_ready.
`include "riscv_config.svh"

module riscv_pipe_stage
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned     DW        = `XLEN,
    parameter logic [DW-1:0]   RESET_VAL = '0
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_clr,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [DW-1:0] o_data,
    output logic [1:0]    o_count
);

    logic          in_xfer;
    logic          out_xfer;
    logic          main_load;
    logic          main_unload;
    logic [DW-1:0] main_din;

    assign in_xfer  = i_valid && o_ready;
    assign out_xfer = o_valid && i_ready;

`ifdef RISCV_PIPE_SKID_EN
    logic          skid_valid;
    logic [DW-1:0] skid_data;
    logic          skid_load;
    logic          skid_unload;

    // o_ready comes straight from the skid valid flop, so i_ready never reaches it.
    // The skid slot can only be full while main is full, which keeps the steering small.
    assign o_ready     = !skid_valid;
    assign main_load   = (in_xfer && (!o_valid || out_xfer)) || (skid_valid && out_xfer);
    assign main_din    = skid_valid ? skid_data : i_data;
    assign main_unload = out_xfer && !main_load;
    assign skid_load   = in_xfer && o_valid && !out_xfer;
    assign skid_unload = skid_valid && out_xfer;

    riscv_pipe_slot #(
        .DW        (DW),
        .RESET_VAL (RESET_VAL)
    ) u_skid (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .i_clr    (i_clr),
        .i_load   (skid_load),
        .i_unload (skid_unload),
        .i_data   (i_data),
        .o_valid  (skid_valid),
        .o_data   (skid_data)
    );

    assign o_count = slot_count(o_valid, skid_valid);
`else
    assign o_ready     = !o_valid || i_ready;
    assign main_load   = in_xfer;
    assign main_din    = i_data;
    assign main_unload = out_xfer && !in_xfer;
    assign o_count     = slot_count(o_valid, 1'b0);
`endif

    riscv_pipe_slot #(
        .DW        (DW),
        .RESET_VAL (RESET_VAL)
    ) u_main (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .i_clr    (i_clr),
        .i_load   (main_load),
        .i_unload (main_unload),
        .i_data   (main_din),
        .o_valid  (o_valid),
        .o_data   (o_data)
    );

endmodule

// File: tb/tb_riscv_pipe_stage.sv
// Directed and randomized checks of riscv_pipe_stage in the configuration selected by RISCV_PIPE_SKID_EN.
`timescale 1ns/1ps

module tb_riscv_pipe_stage;

    localparam int unsigned   DW = 32;
    localparam logic [DW-1:0] RV = 32'h0000_00E7;
`ifdef RISCV_PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic          clk;
    logic          rstn;
    logic          clr;
    logic          in_valid;
    logic          out_ready;
    logic [DW-1:0] in_data;
    logic          stage_ready;
    logic          stage_valid;
    logic [DW-1:0] stage_data;
    logic [1:0]    stage_count;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    riscv_pipe_stage #(
        .DW        (DW),
        .RESET_VAL (RV)
    ) dut (
        .i_clk   (clk),
        .i_rstn  (rstn),
        .i_clr   (clr),
        .i_valid (in_valid),
        .o_ready (stage_ready),
        .i_data  (in_data),
        .o_valid (stage_valid),
        .i_ready (out_ready),
        .o_data  (stage_data),
        .o_count (stage_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [DW-1:0] d,
                              input logic [1:0] c, input logic r);
        check({tag, ".valid"}, 64'(stage_valid), 64'(v));
        check({tag, ".data"},  64'(stage_data),  64'(d));
        check({tag, ".count"}, 64'(stage_count), 64'(c));
        check({tag, ".ready"}, 64'(stage_ready), 64'(r));
    endtask

    // Scoreboard model: a queue of held payloads plus the visible data register.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_data;

    initial begin
        rstn      = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        #12;
        expect_out("reset", 1'b0, RV, 2'd0, 1'b1);
        tick();
        rstn = 1'b1;
        expect_out("post_reset", 1'b0, RV, 2'd0, 1'b1);

        // Streaming 0x10..0x17, one per cycle, one cycle late.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = DW'(32'h10 + i);
            tick();
            expect_out($sformatf("stream%0d", i), 1'b1, DW'(32'h10 + i), 2'd1, 1'b1);
        end
        in_valid = 1'b0;
        tick();
        expect_out("stream_drain", 1'b0, 32'h17, 2'd0, 1'b1);

        // Backpressure: A5 held, B6 waiting (skid slot in skid mode).
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_data   = 32'hA5;
        tick();
        expect_out("bp_load", 1'b1, 32'hA5, SKID ? 2'd1 : 2'd1, SKID ? 1'b1 : 1'b0);
        in_data = 32'hB6;
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_out($sformatf("bp_hold%0d", i), 1'b1, 32'hA5, SKID ? 2'd2 : 2'd1, 1'b0);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        expect_out("bp_release", 1'b1, 32'hB6, 2'd1, 1'b1);
        tick();
        expect_out("bp_drain", 1'b0, 32'hB6, 2'd0, 1'b1);

        // Flush colliding with an input transfer.
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_data   = 32'h33;
        tick();
        in_data   = 32'h5A;
        out_ready = 1'b1;
        clr       = 1'b1;
        #1;
        check("flush_accepting", 64'(stage_ready), 64'(1));
        tick();
        clr      = 1'b0;
        in_valid = 1'b0;
        expect_out("flush", 1'b0, RV, 2'd0, 1'b1);
        tick();
        expect_out("flush_no5a", 1'b0, RV, 2'd0, 1'b1);
        in_valid = 1'b1;
        in_data  = 32'h77;
        tick();
        in_valid = 1'b0;
        expect_out("after_flush", 1'b1, 32'h77, 2'd1, 1'b1);
        tick();

        // Asynchronous reset mid-cycle while holding 0x3C.
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_data   = 32'h3C;
        tick();
        in_valid = 1'b0;
        check("arst_held", 64'(stage_data), 64'(32'h3C));
        #2;
        rstn = 1'b0;
        #1;
        expect_out("arst", 1'b0, RV, 2'd0, 1'b1);
        #3;
        rstn = 1'b1;
        tick();
        expect_out("arst_release", 1'b0, RV, 2'd0, 1'b1);

        // Randomized traffic against the queue model.
        q.delete();
        m_data = RV;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            logic m_ready;
            logic do_in;
            logic do_out;
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            clr       = ($urandom_range(0, 99) < 3);
            in_data   = DW'($urandom);
            m_ready   = SKID ? (q.size() < 2) : (q.size() == 0 || out_ready);
            #1;
            check("rnd.ready", 64'(stage_ready), 64'(m_ready));
            do_in  = in_valid && m_ready;
            do_out = (q.size() > 0) && out_ready;
            @(posedge clk);
            if (clr) begin
                q.delete();
                m_data = RV;
            end else begin
                if (do_out) void'(q.pop_front());
                if (do_in)  q.push_back(in_data);
                if (q.size() > 0) m_data = q[0];
            end
            #1;
            check("rnd.valid", 64'(stage_valid), 64'(q.size() > 0));
            check("rnd.data",  64'(stage_data),  64'(m_data));
            check("rnd.count", 64'(stage_count), 64'(q.size()));
        end
        clr      = 1'b0;
        in_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
